// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// pipe_stage_skid : valid/ready pipeline stage register with optional 2-entry
//                   skid, flush, hold and saturating stall/bubble counters.
// Revision        : 1.0
// ============================================================================
module pipe_stage_skid #(
    parameter int unsigned       WIDTH      = 32,
    parameter int unsigned       SKID       = 1,
    parameter logic [WIDTH-1:0]  BUBBLE_VAL = '0,
    parameter int unsigned       CNTW       = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             flush,
    input  logic             hold,
    output logic [CNTW-1:0]  stall_cnt,
    output logic [CNTW-1:0]  bubble_cnt
);

    localparam logic [1:0]      c_st_empty = 2'd0;
    localparam logic [1:0]      c_st_one   = 2'd1;
    localparam logic [1:0]      c_st_full  = 2'd2;
    localparam logic [CNTW-1:0] c_cnt_max  = '1;
    localparam logic [CNTW-1:0] c_cnt_one  = {{(CNTW-1){1'b0}}, 1'b1};

    logic [1:0]       state_q,      state_d;
    logic [WIDTH-1:0] m_data_q,     m_data_d;
    logic [WIDTH-1:0] s_data_q,     s_data_d;
    logic [CNTW-1:0]  stall_cnt_q,  stall_cnt_d;
    logic [CNTW-1:0]  bubble_cnt_q, bubble_cnt_d;

    logic m_valid;
    logic push;
    logic pop;
    logic count_en;

    assign m_valid  = (state_q != c_st_empty);
    assign push     = in_valid && in_ready;
    assign pop      = out_valid && out_ready;
    assign count_en = !flush && !hold;

    // The skid variant decouples in_ready from out_ready; the plain variant
    // passes downstream readiness straight through.
    generate
        if (SKID != 0) begin : g_ready_skid
            assign in_ready = !flush && !hold && (state_q != c_st_full);
        end else begin : g_ready_direct
            assign in_ready = !flush && !hold && (!m_valid || out_ready);
        end
    endgenerate

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= c_st_empty;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = c_st_empty;
        end else if (!hold) begin
            case (state_q)
                c_st_empty: begin
                    if (push) begin
                        state_d = c_st_one;
                    end
                end
                c_st_one: begin
                    if (push && !pop) begin
                        state_d = (SKID != 0) ? c_st_full : c_st_one;
                    end else if (pop && !push) begin
                        state_d = c_st_empty;
                    end
                end
                c_st_full: begin
                    if (pop) begin
                        state_d = c_st_one;
                    end
                end
                default: state_d = c_st_empty;
            endcase
        end
    end

    always_comb begin
        m_data_d = m_data_q;
        s_data_d = s_data_q;
        if (flush) begin
            m_data_d = BUBBLE_VAL;
            s_data_d = BUBBLE_VAL;
        end else if (!hold) begin
            case (state_q)
                c_st_empty: begin
                    if (push) begin
                        m_data_d = in_data;
                    end
                end
                c_st_one: begin
                    if (push && pop) begin
                        m_data_d = in_data;
                    end else if (push) begin
                        s_data_d = in_data;
                    end
                end
                c_st_full: begin
                    if (pop) begin
                        m_data_d = s_data_q;
                        s_data_d = BUBBLE_VAL;
                    end
                end
                default: begin
                    m_data_d = BUBBLE_VAL;
                    s_data_d = BUBBLE_VAL;
                end
            endcase
        end
    end

    // Data stays visible while frozen so a debugger can see the held payload.
    assign out_valid = m_valid && !hold;
    assign out_data  = m_valid ? m_data_q : BUBBLE_VAL;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            m_data_q <= BUBBLE_VAL;
        end else begin
            m_data_q <= m_data_d;
        end
    end

    generate
        if (SKID != 0) begin : g_skid_entry
            always_ff @(posedge CLK or negedge nRST) begin
                if (!nRST) begin
                    s_data_q <= BUBBLE_VAL;
                end else begin
                    s_data_q <= s_data_d;
                end
            end
        end else begin : g_no_skid_entry
            logic w_unused_s_data;
            assign s_data_q        = BUBBLE_VAL;
            assign w_unused_s_data = ^s_data_d;
        end
    endgenerate

    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (count_en && m_valid && !out_ready && (stall_cnt_q != c_cnt_max)) begin
            stall_cnt_d = stall_cnt_q + c_cnt_one;
        end
        if (count_en && !m_valid && out_ready && (bubble_cnt_q != c_cnt_max)) begin
            bubble_cnt_d = bubble_cnt_q + c_cnt_one;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;

endmodule
`default_nettype wire
